// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 slave responder that turns INCR bursts into
// single-word accesses on a synchronous SRAM macro port. One transaction
// is in flight at a time; AW and AR are granted alternately when both
// are pending.
// Optional build macro: AXI_SLV_RANGE_CHECK_EN -- when defined, beats whose
// byte address has bits set above the SRAM window are answered with DECERR
// and never reach the SRAM; when undefined, upper address bits alias.
module axi_sram_slave #(
    parameter int IDS_W      = 8,
    parameter int DEPTH_LOG2 = 14,
    parameter int LEN_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    // write address channel
    input  logic [IDS_W-1:0]      AWID,
    input  logic [31:0]           AWADDR,
    input  logic [LEN_W-1:0]      AWLEN,
    input  logic [2:0]            AWSIZE,
    input  logic [1:0]            AWBURST,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    // write data channel
    input  logic [31:0]           WDATA,
    input  logic [3:0]            WSTRB,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    // write response channel
    output logic [IDS_W-1:0]      BID,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    // read address channel
    input  logic [IDS_W-1:0]      ARID,
    input  logic [31:0]           ARADDR,
    input  logic [LEN_W-1:0]      ARLEN,
    input  logic [2:0]            ARSIZE,
    input  logic [1:0]            ARBURST,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    // read data channel
    output logic [IDS_W-1:0]      RID,
    output logic [31:0]           RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY,
    // SRAM macro port
    output logic                  sram_cs,
    output logic [3:0]            sram_we,
    output logic [DEPTH_LOG2-1:0] sram_addr,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_DATA,
        S_WR_DATA,
        S_WR_RESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    state_t             r_state;
    logic [IDS_W-1:0]   r_id;
    logic [31:0]        r_addr;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_cnt;
    logic               r_last_rd;    // last grant went to the read side
    logic               r_bresp_err;  // some beat of this write burst was out of range
    logic               r_rd_first;   // first cycle of RD_DATA: SRAM output is live
    logic [31:0]        r_rdata;

    logic               w_awready;
    logic               w_oor;
    logic               w_unused_ok;

`ifdef AXI_SLV_RANGE_CHECK_EN
    assign w_oor = (r_addr >> (DEPTH_LOG2 + 2)) != 32'd0;
`else
    assign w_oor = 1'b0;
`endif

    // Size/burst fields and address bits outside the word index carry no meaning here.
    assign w_unused_ok = ^{AWSIZE, AWBURST, ARSIZE, ARBURST, r_addr};

    // Handshake readies and response channels decoded from registered state.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_awready = (r_state == S_IDLE) && AWVALID && (!ARVALID || r_last_rd);
        AWREADY   = w_awready;
        ARREADY   = (r_state == S_IDLE) && ARVALID && !w_awready;
        WREADY    = (r_state == S_WR_DATA);
        BVALID    = (r_state == S_WR_RESP);
        BID       = r_id;
        BRESP     = (BVALID && r_bresp_err) ? RESP_DECERR : RESP_OKAY;
        RVALID    = (r_state == S_RD_DATA);
        RID       = r_id;
        RLAST     = RVALID && (r_cnt == r_len);
        RRESP     = (RVALID && w_oor) ? RESP_DECERR : RESP_OKAY;
        RDATA     = 32'd0;
        if (RVALID && !w_oor) begin
            // The SRAM word is only guaranteed on the first cycle; later stall cycles replay the capture.
            RDATA = r_rd_first ? sram_rdata : r_rdata;
        end
    end

    // SRAM port: driven only while a write beat or read request is being issued.
    always_comb begin
        sram_cs    = 1'b0;
        sram_we    = 4'h0;
        sram_addr  = '0;
        sram_wdata = 32'd0;
        if (r_state == S_WR_DATA && WVALID && !w_oor) begin
            sram_cs    = 1'b1;
            sram_we    = WSTRB;
            sram_addr  = r_addr[DEPTH_LOG2+1:2];
            sram_wdata = WDATA;
        end else if (r_state == S_RD_REQ && !w_oor) begin
            sram_cs    = 1'b1;
            sram_addr  = r_addr[DEPTH_LOG2+1:2];
        end
    end

    // Transaction FSM: latches the request, walks the burst, returns the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state     <= S_IDLE;
            r_id        <= '0;
            r_addr      <= 32'd0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_last_rd   <= 1'b0;
            r_bresp_err <= 1'b0;
            r_rd_first  <= 1'b0;
            r_rdata     <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_awready) begin
                        r_id        <= AWID;
                        r_addr      <= AWADDR;
                        r_len       <= AWLEN;
                        r_cnt       <= '0;
                        r_last_rd   <= 1'b0;
                        r_bresp_err <= 1'b0;
                        r_state     <= S_WR_DATA;
                    end else if (ARVALID) begin
                        r_id      <= ARID;
                        r_addr    <= ARADDR;
                        r_len     <= ARLEN;
                        r_cnt     <= '0;
                        r_last_rd <= 1'b1;
                        r_state   <= S_RD_REQ;
                    end
                end
                S_WR_DATA: begin
                    if (WVALID) begin
                        if (w_oor) begin
                            r_bresp_err <= 1'b1;
                        end
                        r_addr <= r_addr + 32'd4;
                        r_cnt  <= r_cnt + LEN_W'(1);
                        if (WLAST) begin
                            r_state <= S_WR_RESP;
                        end
                    end
                end
                S_WR_RESP: begin
                    if (BREADY) begin
                        r_state <= S_IDLE;
                    end
                end
                S_RD_REQ: begin
                    r_rd_first <= 1'b1;
                    r_state    <= S_RD_DATA;
                end
                S_RD_DATA: begin
                    r_rd_first <= 1'b0;
                    if (r_rd_first) begin
                        r_rdata <= sram_rdata;
                    end
                    if (RREADY) begin
                        if (r_cnt == r_len) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_addr  <= r_addr + 32'd4;
                            r_cnt   <= r_cnt + LEN_W'(1);
                            r_state <= S_RD_REQ;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed bench for axi_sram_slave with a behavioural
// synchronous SRAM. Define AXI_SLV_RANGE_CHECK_EN for both files together
// to exercise the out-of-range responses.
module tb_axi_sram_slave;

    localparam int IDS_W      = 8;
    localparam int DEPTH_LOG2 = 14;
    localparam int LEN_W      = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [IDS_W-1:0]      AWID, ARID, BID, RID;
    logic [31:0]           AWADDR, ARADDR, WDATA, RDATA;
    logic [LEN_W-1:0]      AWLEN, ARLEN;
    logic [2:0]            AWSIZE, ARSIZE;
    logic [1:0]            AWBURST, ARBURST, BRESP, RRESP;
    logic                  AWVALID, AWREADY, WLAST, WVALID, WREADY;
    logic                  BVALID, BREADY, ARVALID, ARREADY;
    logic                  RLAST, RVALID, RREADY;
    logic [3:0]            WSTRB;
    logic                  sram_cs;
    logic [3:0]            sram_we;
    logic [DEPTH_LOG2-1:0] sram_addr;
    logic [31:0]           sram_wdata;
    logic [31:0]           sram_rdata;

    always #5 clk = ~clk;

    axi_sram_slave #(.IDS_W(IDS_W), .DEPTH_LOG2(DEPTH_LOG2), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // Behavioural SRAM: byte-enabled write, registered read.
    logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];
    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we != 4'h0) begin
                for (int b = 0; b < 4; b++)
                    if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_idle_zero(input string name);
        check(name, {AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST, BRESP, RRESP, sram_cs, sram_we},
              '0);
        check({name, "_data"}, {BID, RID, RDATA, sram_addr}, '0);
    endtask

    // All tasks start and end on a falling edge.
    task automatic aw_send(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
        bit ok = 0;
        AWID = id; AWADDR = addr; AWLEN = len; AWVALID = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (AWREADY === 1'b1) ok = 1;
            @(negedge clk);
        end
        AWVALID = 1'b0;
        check("aw_handshake", 64'(ok), 64'd1);
    endtask

    task automatic ar_send(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
        bit ok = 0;
        ARID = id; ARADDR = addr; ARLEN = len; ARVALID = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (ARREADY === 1'b1) ok = 1;
            @(negedge clk);
        end
        ARVALID = 1'b0;
        check("ar_handshake", 64'(ok), 64'd1);
    endtask

    task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last,
                          output logic cs, output logic [3:0] we, output logic [13:0] waddr);
        bit ok = 0;
        cs = 1'b0; we = 4'h0; waddr = '0;
        WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (WREADY === 1'b1) begin
                ok = 1; cs = sram_cs; we = sram_we; waddr = sram_addr;
            end
            @(negedge clk);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        check("w_handshake", 64'(ok), 64'd1);
    endtask

    task automatic b_recv(output logic [7:0] bid, output logic [1:0] bresp);
        bit ok = 0;
        bid = '0; bresp = '0;
        BREADY = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (BVALID === 1'b1) begin
                ok = 1; bid = BID; bresp = BRESP;
            end
            @(negedge clk);
        end
        BREADY = 1'b0;
        check("b_handshake", 64'(ok), 64'd1);
    endtask

    // Waits for RVALID, holds RREADY low for 'stall' cycles checking stability, then accepts.
    task automatic r_recv(input int stall, output logic [31:0] data, output logic [1:0] resp,
                          output logic last, output logic [7:0] id, output int waited);
        bit ok = 0;
        data = '0; resp = '0; last = 1'b0; id = '0; waited = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (RVALID === 1'b1) ok = 1;
            else begin
                @(negedge clk);
                waited++;
            end
        end
        check("r_valid_seen", 64'(ok), 64'd1);
        if (ok) begin
            data = RDATA; resp = RRESP; last = RLAST; id = RID;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                #1;
                check("r_stall_hold", {RVALID, RDATA, RRESP, RLAST, RID},
                      {1'b1, data, resp, last, id});
            end
            RREADY = 1'b1;
            @(negedge clk);
            RREADY = 1'b0;
        end
    endtask

    typedef struct {
        bit          wr;
        logic [7:0]  id;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [13:0] exp_word;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vt[8];

    logic        cs, lst;
    logic [3:0]  we;
    logic [13:0] wa;
    logic [7:0]  bid, rid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    int          waited;
    bit          exp_rd;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << DEPTH_LOG2); i++) mem[i] = 32'd0;
        sram_rdata = 32'd0;
        rst = 1'b1;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b0;
        RREADY = 1'b0;

        vt[0] = '{1'b1, 8'h01, 32'h10, 32'hDEADBEEF, 4'hF,    14'd4,  32'h0};
        vt[1] = '{1'b0, 8'h02, 32'h10, 32'h0,        4'h0,    14'd4,  32'hDEADBEEF};
        vt[2] = '{1'b1, 8'h03, 32'h20, 32'h11223344, 4'hF,    14'd8,  32'h0};
        vt[3] = '{1'b1, 8'h04, 32'h20, 32'hAABBCCDD, 4'b0010, 14'd8,  32'h0};
        vt[4] = '{1'b0, 8'h05, 32'h20, 32'h0,        4'h0,    14'd8,  32'h1122CC44};
        vt[5] = '{1'b1, 8'h06, 32'h40, 32'hCAFEF00D, 4'b1100, 14'd16, 32'h0};
        vt[6] = '{1'b0, 8'h07, 32'h40, 32'h0,        4'h0,    14'd16, 32'hCAFE0000};
        vt[7] = '{1'b1, 8'h08, 32'h00, 32'h0BADF00D, 4'hF,    14'd0,  32'h0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_zero("reset_outputs");
        @(negedge clk);

        // Simultaneous AW/AR after reset: grants go READ, WRITE, READ.
        for (int i = 0; i < 3; i++) begin
            exp_rd = (i % 2 == 0);
            AWID = 8'h15; AWADDR = 32'h200; AWLEN = '0; AWVALID = 1'b1;
            ARID = 8'h2A; ARADDR = 32'h10;  ARLEN = '0; ARVALID = 1'b1;
            #1;
            check("arb_grant", {AWREADY, ARREADY}, exp_rd ? 2'b01 : 2'b10);
            @(negedge clk);
            AWVALID = 1'b0; ARVALID = 1'b0;
            if (exp_rd) begin
                r_recv(0, rdata, rresp, lst, rid, waited);
                check("arb_rid", {rid, lst, rresp}, {8'h2A, 1'b1, 2'b00});
            end else begin
                w_send(32'h12345678, 4'hF, 1'b1, cs, we, wa);
                b_recv(bid, bresp);
                check("arb_bid", {bid, bresp}, {8'h15, 2'b00});
            end
        end

        // Single-beat table.
        for (int i = 0; i < 8; i++) begin
            if (vt[i].wr) begin
                aw_send(vt[i].id, vt[i].addr, 4'd0);
                w_send(vt[i].data, vt[i].strb, 1'b1, cs, we, wa);
                check("wr_sram_port", {cs, we, wa}, {1'b1, vt[i].strb, vt[i].exp_word});
                b_recv(bid, bresp);
                check("wr_bresp", {bid, bresp}, {vt[i].id, 2'b00});
            end else begin
                ar_send(vt[i].id, vt[i].addr, 4'd0);
                r_recv(0, rdata, rresp, lst, rid, waited);
                check("rd_latency", 64'(waited), 64'd1);
                check("rd_beat", {rdata, rresp, lst, rid}, {vt[i].exp_rdata, 2'b00, 1'b1, vt[i].id});
            end
        end

        // 4-beat write then 4-beat read with RREADY stalls.
        aw_send(8'h31, 32'h100, 4'd3);
        for (int b = 0; b < 4; b++) begin
            w_send(32'hB000_0000 + 32'(b), 4'hF, b == 3, cs, we, wa);
            check("burst_wr_addr", {cs, we, wa}, {1'b1, 4'hF, 14'(64 + b)});
        end
        b_recv(bid, bresp);
        check("burst_bresp", {bid, bresp}, {8'h31, 2'b00});
        ar_send(8'h32, 32'h100, 4'd3);
        for (int b = 0; b < 4; b++) begin
            r_recv(1, rdata, rresp, lst, rid, waited);
            check("burst_rd_beat", {rdata, rresp, lst, rid},
                  {32'hB000_0000 + 32'(b), 2'b00, (b == 3), 8'h32});
        end

        // Addresses above the SRAM window.
        aw_send(8'h41, 32'h0001_0004, 4'd0);
        w_send(32'h0000_0077, 4'hF, 1'b1, cs, we, wa);
        b_recv(bid, bresp);
        ar_send(8'h42, 32'h0001_0000, 4'd0);
        r_recv(0, rdata, rresp, lst, rid, waited);
`ifdef AXI_SLV_RANGE_CHECK_EN
        check("oor_wr_blocked", {cs, bid, bresp}, {1'b0, 8'h41, 2'b11});
        check("oor_rd", {rdata, rresp, lst, rid}, {32'h0, 2'b11, 1'b1, 8'h42});
`else
        check("alias_wr", {cs, wa, bid, bresp}, {1'b1, 14'd1, 8'h41, 2'b00});
        check("alias_rd", {rdata, rresp, lst, rid}, {32'h0BADF00D, 2'b00, 1'b1, 8'h42});
`endif

        // Reset after beat 2 of a 4-beat write burst.
        aw_send(8'h51, 32'h300, 4'd3);
        for (int b = 0; b < 2; b++) w_send(32'hC0DE_0000 + 32'(b), 4'hF, 1'b0, cs, we, wa);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        WDATA = 32'hFFFF_FFFF; WSTRB = 4'hF; WVALID = 1'b1;
        #1;
        check_idle_zero("abort_outputs");
        @(negedge clk);
        WVALID = 1'b0;
        ar_send(8'h52, 32'h300, 4'd3);
        for (int b = 0; b < 4; b++) begin
            r_recv(0, rdata, rresp, lst, rid, waited);
            check("abort_rd_beat", {rdata, lst},
                  {(b < 2) ? 32'hC0DE_0000 + 32'(b) : 32'h0, (b == 3)});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
